tof_i2c_sequencer: RTL and testbench
====================================

Name: tof_i2c_sequencer

Overview:
Autonomous controller that owns the I2C_Entity command interface and drives the ToF sensor (7-bit address 0x29) through init and continuous ranging. Walks an external init table of 16-bit-register/8-bit-value writes, starts ranging, polls data-ready, reads the 16-bit distance, then clears the interrupt, in a loop. Sits between the top-level control logic and I2C_Entity, and publishes distance samples plus fault status.

Parameters:
SLAVE_ADDR, 7'h29, I2C slave address driven on i2c_slave_addr
INIT_LEN, 8'd4, number of init table entries (1..255)
MAX_RETRY, 2, re-issues of a transaction after i2c_error before fault
POLL_MAX, 16'd1000, data-ready polls per measurement before fault
ACCEPT_TIMEOUT, 16'd255, cycles to wait for i2c_ready to fall after start

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run init then ranging loop, 0 = stop after current transaction
tbl_idx  out  8  init table index
tbl_entry  in  24  {reg_addr[15:0], value[7:0]}, combinational, valid same cycle as tbl_idx
i2c_start  out  1  one-cycle command strobe to I2C_Entity
i2c_is_read  out  1  1 = read, 0 = write
i2c_slave_addr  out  7  constant SLAVE_ADDR
i2c_reg_addr  out  16  register address
i2c_data_in  out  8  write byte
i2c_nb_bytes  out  10  transfer length
i2c_ready  in  1  1 = I2C_Entity idle
i2c_error  in  1  NACK/fault flag, sampled when i2c_ready rises
i2c_data_out  in  16  read data; 1-byte read in [7:0], 2-byte read = {first byte, second byte}
distance  out  16  last distance sample, mm
distance_valid  out  1  one-cycle pulse when distance updates
init_done  out  1  level, set after last init write completes
busy  out  1  1 while a transaction is outstanding
fault  out  1  sticky fault flag
fault_code  out  3  0 none, 1 I2C error after retries, 2 poll timeout, 3 accept timeout

Behaviour:
- Reset (async): all outputs 0, i2c_slave_addr = SLAVE_ADDR, state IDLE, tbl_idx 0, retry/poll counters 0.
- Transaction engine, used by every step: ISSUE drives the command fields and pulses i2c_start for exactly one cycle, only when i2c_ready=1. Otherwise it holds and waits. ACCEPT waits for i2c_ready=0; ACCEPT_TIMEOUT cycles without it -> FAULT code 3. DONE waits for i2c_ready=1, then samples i2c_error and i2c_data_out on that cycle.
- Command fields stay stable from the ISSUE cycle until DONE completes. busy=1 from the ISSUE strobe through the DONE cycle.
- On i2c_error=1: re-issue the same transaction if retry<MAX_RETRY, incrementing retry; otherwise go to FAULT code 1. retry clears on every successful transaction.
- Main FSM:
  - IDLE: enable=1 and init_done=0 -> INIT. enable=1 and init_done=1 -> START_RNG.
  - INIT: write tbl_entry[23:8] <- tbl_entry[7:0], nb=1. Success increments tbl_idx. When tbl_idx=INIT_LEN-1 completes, set init_done=1 and go to START_RNG.
  - START_RNG: write 0x0087 <- 0x40, nb=1 -> POLL, poll count 0.
  - POLL: read 0x0031, nb=1. If data_out[0]=0 (data ready, active-low) -> READ_DIST. Otherwise increment poll count and re-issue. Count reaching POLL_MAX -> FAULT code 2.
  - READ_DIST: read 0x0096, nb=2. Latch distance=i2c_data_out and pulse distance_valid the cycle after DONE -> CLR_INT.
  - CLR_INT: write 0x0086 <- 0x01, nb=1. Then enable=1 -> POLL, enable=0 -> IDLE.
  - FAULT: fault=1; no further starts. Exit to IDLE only when enable=0. That exit clears fault, fault_code and init_done, and sets tbl_idx=0 so init reruns.
- enable falling mid-transaction: the current transaction completes, including retries, then the FSM goes to IDLE. It never abandons I2C_Entity while busy.
- enable falling during INIT: return to IDLE with tbl_idx held. A later enable resumes at the same index.
- Reset mid-transaction: immediate return to reset values. The engine then waits for i2c_ready=1 before the first ISSUE.
- i2c_error while ready=0 is ignored.

Test Plan:
1. INIT_LEN=2, table {0x002D,0x01},{0x0030,0x02}, slave always acks -> two writes in table order, each nb=1, then init_done=1 and 0x0087<-0x40 issued; i2c_start is never high for 2 consecutive cycles.
2. Poll returns 0x01, 0x01, 0x00, then distance read returns 0x01F4 -> exactly 3 polls, distance=500, one distance_valid pulse, then write 0x0086<-0x01.
3. i2c_error on first attempt of READ_DIST, success on retry -> same command re-issued once, no fault, distance valid.
4. i2c_error on 3 consecutive attempts of an init write (MAX_RETRY=2) -> fault=1, fault_code=1, no further starts; enable 0 -> fault cleared, init_done=0, tbl_idx=0.
5. POLL_MAX=4, data-ready never set -> 4 polls, fault_code=2.
6. i2c_ready held 1 after start for ACCEPT_TIMEOUT cycles -> fault_code=3; then reset asserted mid-wait -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/tof_i2c_sequencer.sv
// Autonomous I2C command sequencer for the ToF sensor: replays an init table, starts
// ranging, then loops poll / distance read / interrupt clear with retry and fault tracking.
module tof_i2c_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h29,
  parameter logic [7:0]  INIT_LEN       = 8'd4,
  parameter int          MAX_RETRY      = 2,
  parameter logic [15:0] POLL_MAX       = 16'd1000,
  parameter logic [15:0] ACCEPT_TIMEOUT = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [7:0]  tbl_idx,
  input  logic [23:0] tbl_entry,
  output logic        i2c_start,
  output logic        i2c_is_read,
  output logic [6:0]  i2c_slave_addr,
  output logic [15:0] i2c_reg_addr,
  output logic [7:0]  i2c_data_in,
  output logic [9:0]  i2c_nb_bytes,
  input  logic        i2c_ready,
  input  logic        i2c_error,
  input  logic [15:0] i2c_data_out,
  output logic [15:0] distance,
  output logic        distance_valid,
  output logic        init_done,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  fault_code
);

  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);
  localparam logic [2:0] FC_I2C    = 3'd1;
  localparam logic [2:0] FC_POLL   = 3'd2;
  localparam logic [2:0] FC_ACCEPT = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_START_RNG, S_POLL, S_READ_DIST, S_CLR_INT, S_FAULT
  } state_t;

  typedef enum logic [1:0] {P_ISSUE, P_ACCEPT, P_DONE} phase_t;

  state_t      state, state_nx;
  phase_t      phase, phase_nx;
  logic [7:0]  tbl_idx_nx, retry, retry_nx;
  logic [15:0] poll_cnt, poll_cnt_nx, timer, timer_nx;
  logic        init_done_nx, fault_nx, start_nx, dv_nx;
  logic [2:0]  fault_code_nx;
  logic [15:0] distance_nx;
  logic        rd_nx;
  logic [15:0] reg_nx;
  logic [7:0]  din_nx;
  logic [9:0]  nb_nx;
  logic        cmd_rd;
  logic [15:0] cmd_reg;
  logic [7:0]  cmd_data;
  logic [9:0]  cmd_nb;

  assign i2c_slave_addr = SLAVE_ADDR;
  assign busy           = (phase != P_ISSUE);

  always_comb begin
    state_nx      = state;
    phase_nx      = phase;
    tbl_idx_nx    = tbl_idx;
    retry_nx      = retry;
    poll_cnt_nx   = poll_cnt;
    timer_nx      = timer;
    init_done_nx  = init_done;
    fault_nx      = fault;
    fault_code_nx = fault_code;
    distance_nx   = distance;
    dv_nx         = 1'b0;
    start_nx      = 1'b0;
    rd_nx         = i2c_is_read;
    reg_nx        = i2c_reg_addr;
    din_nx        = i2c_data_in;
    nb_nx         = i2c_nb_bytes;
    cmd_rd        = 1'b0;
    cmd_reg       = 16'h0000;
    cmd_data      = 8'h00;
    cmd_nb        = 10'd1;

    case (state)
      S_INIT:      begin cmd_reg = tbl_entry[23:8]; cmd_data = tbl_entry[7:0]; end
      S_START_RNG: begin cmd_reg = 16'h0087; cmd_data = 8'h40; end
      S_POLL:      begin cmd_rd = 1'b1; cmd_reg = 16'h0031; end
      S_READ_DIST: begin cmd_rd = 1'b1; cmd_reg = 16'h0096; cmd_nb = 10'd2; end
      S_CLR_INT:   begin cmd_reg = 16'h0086; cmd_data = 8'h01; end
      default: ;
    endcase

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = init_done ? S_START_RNG : S_INIT;
          phase_nx = P_ISSUE;
          retry_nx = 8'd0;
        end
      end
      S_FAULT: begin
        // Leaving FAULT forces a full re-init on the next enable.
        if (!enable) begin
          state_nx      = S_IDLE;
          fault_nx      = 1'b0;
          fault_code_nx = 3'd0;
          init_done_nx  = 1'b0;
          tbl_idx_nx    = 8'd0;
          retry_nx      = 8'd0;
          poll_cnt_nx   = 16'd0;
        end
      end
      default: begin
        case (phase)
          P_ISSUE: begin
            if (i2c_ready) begin
              start_nx = 1'b1;
              rd_nx    = cmd_rd;
              reg_nx   = cmd_reg;
              din_nx   = cmd_data;
              nb_nx    = cmd_nb;
              timer_nx = 16'd0;
              phase_nx = P_ACCEPT;
            end
          end
          P_ACCEPT: begin
            if (!i2c_ready) begin
              phase_nx = P_DONE;
            end else if (timer == ACCEPT_TIMEOUT - 16'd1) begin
              state_nx      = S_FAULT;
              phase_nx      = P_ISSUE;
              fault_nx      = 1'b1;
              fault_code_nx = FC_ACCEPT;
            end else begin
              timer_nx = timer + 16'd1;
            end
          end
          P_DONE: begin
            if (i2c_ready) begin
              phase_nx = P_ISSUE;
              if (i2c_error) begin
                // Retries run even with enable low so the transaction always completes.
                if (retry < RETRY_LIM) begin
                  retry_nx = retry + 8'd1;
                end else begin
                  state_nx      = S_FAULT;
                  fault_nx      = 1'b1;
                  fault_code_nx = FC_I2C;
                end
              end else begin
                retry_nx = 8'd0;
                case (state)
                  S_INIT: begin
                    if (tbl_idx == INIT_LEN - 8'd1) begin
                      init_done_nx = 1'b1;
                      state_nx     = enable ? S_START_RNG : S_IDLE;
                    end else begin
                      tbl_idx_nx = tbl_idx + 8'd1;
                      state_nx   = enable ? S_INIT : S_IDLE;
                    end
                  end
                  S_START_RNG: begin
                    poll_cnt_nx = 16'd0;
                    state_nx    = enable ? S_POLL : S_IDLE;
                  end
                  S_POLL: begin
                    if (!i2c_data_out[0]) begin
                      state_nx = enable ? S_READ_DIST : S_IDLE;
                    end else if (poll_cnt + 16'd1 == POLL_MAX) begin
                      state_nx      = S_FAULT;
                      fault_nx      = 1'b1;
                      fault_code_nx = FC_POLL;
                    end else begin
                      poll_cnt_nx = poll_cnt + 16'd1;
                      state_nx    = enable ? S_POLL : S_IDLE;
                    end
                  end
                  S_READ_DIST: begin
                    distance_nx = i2c_data_out;
                    dv_nx       = 1'b1;
                    state_nx    = enable ? S_CLR_INT : S_IDLE;
                  end
                  S_CLR_INT: begin
                    poll_cnt_nx = 16'd0;
                    state_nx    = enable ? S_POLL : S_IDLE;
                  end
                  default: state_nx = S_IDLE;
                endcase
              end
            end
          end
          default: phase_nx = P_ISSUE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      phase          <= P_ISSUE;
      tbl_idx        <= 8'd0;
      retry          <= 8'd0;
      poll_cnt       <= 16'd0;
      timer          <= 16'd0;
      init_done      <= 1'b0;
      fault          <= 1'b0;
      fault_code     <= 3'd0;
      distance       <= 16'd0;
      distance_valid <= 1'b0;
      i2c_start      <= 1'b0;
      i2c_is_read    <= 1'b0;
      i2c_reg_addr   <= 16'd0;
      i2c_data_in    <= 8'd0;
      i2c_nb_bytes   <= 10'd0;
    end else begin
      state          <= state_nx;
      phase          <= phase_nx;
      tbl_idx        <= tbl_idx_nx;
      retry          <= retry_nx;
      poll_cnt       <= poll_cnt_nx;
      timer          <= timer_nx;
      init_done      <= init_done_nx;
      fault          <= fault_nx;
      fault_code     <= fault_code_nx;
      distance       <= distance_nx;
      distance_valid <= dv_nx;
      i2c_start      <= start_nx;
      i2c_is_read    <= rd_nx;
      i2c_reg_addr   <= reg_nx;
      i2c_data_in    <= din_nx;
      i2c_nb_bytes   <= nb_nx;
    end
  end

endmodule

// File: tb/tb_tof_i2c_sequencer.sv
// Directed bench for tof_i2c_sequencer: an I2C_Entity model answers from a response
// queue while command and distance scoreboards are checked as the DUT emits them.
module tb_tof_i2c_sequencer;

  typedef struct packed {
    logic        rd;
    logic [15:0] ra;
    logic [7:0]  d;
    logic [9:0]  nb;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [7:0]  tbl_idx;
  logic [23:0] tbl_entry;
  logic        i2c_start, i2c_is_read;
  logic [6:0]  i2c_slave_addr;
  logic [15:0] i2c_reg_addr;
  logic [7:0]  i2c_data_in;
  logic [9:0]  i2c_nb_bytes;
  logic        i2c_ready, i2c_error;
  logic [15:0] i2c_data_out;
  logic [15:0] distance;
  logic        distance_valid, init_done, busy, fault;
  logic [2:0]  fault_code;

  cmd_t        exp_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] dist_q[$];
  int          total = 0;
  int          passed = 0;
  logic        hang = 1'b0;
  logic        prev_start = 1'b0;
  int          s_cnt = 0;
  rsp_t        cur = '0;

  tof_i2c_sequencer #(
    .SLAVE_ADDR(7'h29), .INIT_LEN(8'd2), .MAX_RETRY(2),
    .POLL_MAX(16'd4), .ACCEPT_TIMEOUT(16'd20)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .i2c_start(i2c_start), .i2c_is_read(i2c_is_read),
    .i2c_slave_addr(i2c_slave_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_data_in(i2c_data_in), .i2c_nb_bytes(i2c_nb_bytes),
    .i2c_ready(i2c_ready), .i2c_error(i2c_error), .i2c_data_out(i2c_data_out),
    .distance(distance), .distance_valid(distance_valid),
    .init_done(init_done), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  assign tbl_entry = (tbl_idx == 8'd0) ? 24'h002D01 :
                     (tbl_idx == 8'd1) ? 24'h003002 : 24'hFFFFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_w(input logic [15:0] ra, input logic [7:0] d, input logic err);
    exp_q.push_back({1'b0, ra, d, 10'd1});
    rsp_q.push_back({err, 16'h0000});
  endtask

  task automatic push_r(input logic [15:0] ra, input logic [9:0] nb,
                        input logic err, input logic [15:0] data);
    exp_q.push_back({1'b1, ra, 8'h00, nb});
    rsp_q.push_back({err, data});
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return distance_valid;
      1:       return fault;
      2:       return (exp_q.size() == 0) && !busy;
      default: return i2c_start;
    endcase
  endfunction

  task automatic wait_cond(input string tag, input int which, input int max);
    int n = 0;
    while (!cond(which) && n < max) begin
      @(negedge clock);
      n++;
    end
    check(tag, (n < max), 1);
  endtask

  // I2C_Entity model: drops ready the cycle after a start, answers three cycles later.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      i2c_ready    <= 1'b1;
      i2c_error    <= 1'b0;
      i2c_data_out <= 16'h0000;
      s_cnt        <= 0;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        i2c_ready    <= 1'b1;
        i2c_error    <= cur.err;
        i2c_data_out <= cur.data;
      end
    end else if (i2c_start && !hang) begin
      i2c_ready <= 1'b0;
      i2c_error <= 1'b0;
      s_cnt     <= 3;
      if (rsp_q.size() != 0) cur <= rsp_q.pop_front();
      else cur <= '0;
    end
  end

  always @(negedge clock) begin
    cmd_t e;
    if (i2c_start) begin
      check("start_single_cycle", prev_start, 0);
      check("start_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cmd_is_read", i2c_is_read, e.rd);
        check("cmd_reg_addr", i2c_reg_addr, e.ra);
        check("cmd_nb_bytes", i2c_nb_bytes, e.nb);
        check("cmd_slave_addr", i2c_slave_addr, 7'h29);
        if (!e.rd) check("cmd_data_in", i2c_data_in, e.d);
      end
    end
    prev_start <= i2c_start;
    if (distance_valid) begin
      check("dist_expected", (dist_q.size() != 0), 1);
      if (dist_q.size() != 0) check("distance", distance, dist_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_start", i2c_start, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_code", fault_code, 0);
    check("rst_init_done", init_done, 0);
    check("rst_tbl_idx", tbl_idx, 0);
    check("rst_distance", distance, 0);
    check("rst_dv", distance_valid, 0);
    check("rst_slave_addr", i2c_slave_addr, 7'h29);
    check("rst_reg_addr", i2c_reg_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    // Init table, start ranging, three polls, distance 500, interrupt clear
    push_w(16'h002D, 8'h01, 1'b0);
    push_w(16'h0030, 8'h02, 1'b0);
    push_w(16'h0087, 8'h40, 1'b0);
    push_r(16'h0031, 10'd1, 1'b0, 16'h0001);
    push_r(16'h0031, 10'd1, 1'b0, 16'h0001);
    push_r(16'h0031, 10'd1, 1'b0, 16'h0000);
    push_r(16'h0096, 10'd2, 1'b0, 16'h01F4);
    dist_q.push_back(16'd500);
    push_w(16'h0086, 8'h01, 1'b0);
    enable = 1'b1;
    wait_cond("t2_wait_dv", 0, 1000);
    enable = 1'b0;
    wait_cond("t2_wait_drain", 2, 300);
    repeat (5) @(negedge clock);
    check("t1_init_done", init_done, 1);
    check("t2_no_fault", fault, 0);
    check("t2_cmds_consumed", exp_q.size(), 0);
    check("t2_dist_consumed", dist_q.size(), 0);
    check("t2_distance_held", distance, 16'd500);

    // Distance read errors once, retried with identical command
    push_w(16'h0087, 8'h40, 1'b0);
    push_r(16'h0031, 10'd1, 1'b0, 16'h0000);
    push_r(16'h0096, 10'd2, 1'b1, 16'hDEAD);
    push_r(16'h0096, 10'd2, 1'b0, 16'h0123);
    dist_q.push_back(16'h0123);
    push_w(16'h0086, 8'h01, 1'b0);
    enable = 1'b1;
    wait_cond("t3_wait_dv", 0, 1000);
    enable = 1'b0;
    wait_cond("t3_wait_drain", 2, 300);
    repeat (5) @(negedge clock);
    check("t3_no_fault", fault, 0);
    check("t3_fault_code", fault_code, 0);
    check("t3_cmds_consumed", exp_q.size(), 0);

    // Data-ready never asserted: four polls then poll timeout
    push_w(16'h0087, 8'h40, 1'b0);
    for (int i = 0; i < 4; i++) push_r(16'h0031, 10'd1, 1'b0, 16'h0001);
    enable = 1'b1;
    wait_cond("t5_wait_fault", 1, 1000);
    repeat (20) @(negedge clock);
    check("t5_fault", fault, 1);
    check("t5_fault_code", fault_code, 2);
    check("t5_cmds_consumed", exp_q.size(), 0);
    check("t5_busy", busy, 0);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("t5_clr_fault", fault, 0);
    check("t5_clr_code", fault_code, 0);
    check("t5_clr_init_done", init_done, 0);
    check("t5_clr_tbl_idx", tbl_idx, 0);

    // Init write NACKed three times -> I2C fault
    for (int i = 0; i < 3; i++) push_w(16'h002D, 8'h01, 1'b1);
    enable = 1'b1;
    wait_cond("t4_wait_fault", 1, 1000);
    repeat (20) @(negedge clock);
    check("t4_fault", fault, 1);
    check("t4_fault_code", fault_code, 1);
    check("t4_cmds_consumed", exp_q.size(), 0);
    check("t4_init_done", init_done, 0);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("t4_clr_fault", fault, 0);
    check("t4_clr_code", fault_code, 0);
    check("t4_clr_init_done", init_done, 0);
    check("t4_clr_tbl_idx", tbl_idx, 0);

    // Entity never accepts -> accept timeout, then async reset during a wait
    hang = 1'b1;
    exp_q.push_back({1'b0, 16'h002D, 8'h01, 10'd1});
    enable = 1'b1;
    wait_cond("t6_wait_fault", 1, 1000);
    check("t6_fault", fault, 1);
    check("t6_fault_code", fault_code, 3);
    check("t6_busy_after_fault", busy, 0);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_clr_fault", fault, 0);
    exp_q.push_back({1'b0, 16'h002D, 8'h01, 10'd1});
    enable = 1'b1;
    wait_cond("t6_wait_start", 3, 100);
    @(negedge clock);
    check("t6_busy_waiting", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_start", i2c_start, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_reg_addr", i2c_reg_addr, 0);
    check("t6_async_nb", i2c_nb_bytes, 0);
    check("t6_async_fault", fault, 0);
    check("t6_async_tbl_idx", tbl_idx, 0);
    check("t6_async_slave_addr", i2c_slave_addr, 7'h29);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    hang  = 1'b0;
    repeat (3) @(negedge clock);
    check("end_cmds_consumed", exp_q.size(), 0);
    check("end_rsps_consumed", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
